// File: rtl/decode_2_4_pkg.sv
// Shared definitions for the decode_2_4 one-hot encoder:
// index constants, index type, popcount and priority-encode helpers.
package decode_2_4_pkg;

    typedef logic [1:0] idx_t;

    localparam idx_t IDX_S1 = 2'b00;
    localparam idx_t IDX_S2 = 2'b01;
    localparam idx_t IDX_S3 = 2'b10;
    localparam idx_t IDX_S4 = 2'b11;

    // Number of set bits in a 4-bit select vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Index of the lowest set bit; all-zero maps to IDX_S1.
    function automatic idx_t prio_enc4(input logic [3:0] v);
        if (v[0])      prio_enc4 = IDX_S1;
        else if (v[1]) prio_enc4 = IDX_S2;
        else if (v[2]) prio_enc4 = IDX_S3;
        else if (v[3]) prio_enc4 = IDX_S4;
        else           prio_enc4 = IDX_S1;
    endfunction

endpackage

// File: rtl/decode_2_4_onehot_check.sv
// Combinational legality check for a 4-bit select vector.
// Reports whether exactly one bit is set and the lowest set bit's index,
// which for a one-hot vector is simply the index of the active line.
module decode_2_4_onehot_check
    import decode_2_4_pkg::*;
(
    input  logic [3:0] vec_i,
    output logic       is_onehot_o,
    output idx_t       prio_idx_o
);

    // Legality and priority index are both pure functions of the vector.
    always_comb begin
        is_onehot_o = (popcount4(vec_i) == 3'd1);
        prio_idx_o  = prio_enc4(vec_i);
    end

endmodule

// File: rtl/decode_2_4_enc.sv
// Registered 4-to-2 one-hot encoder with legality flag.
// Outputs reflect the select vector sampled at the previous rising edge.
// Build option DECODE_2_4_HOLD_EN: when defined, an illegal vector keeps the
// previous decode value instead of priority-encoding it; legal still drops.
module decode_2_4_enc
    import decode_2_4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    input  logic       s4,
    output logic [1:0] decode,
    output logic       legal
);

    logic [3:0] vec;
    logic       is_onehot;
    idx_t       prio_idx;
    idx_t       decode_d;
    idx_t       decode_q;
    logic       legal_d;
    logic       legal_q;

    assign vec = {s4, s3, s2, s1};

    decode_2_4_onehot_check u_onehot_check (
        .vec_i       (vec),
        .is_onehot_o (is_onehot),
        .prio_idx_o  (prio_idx)
    );

    // Next-state selection: priority index, or held value for illegal input in hold builds.
    always_comb begin
        legal_d  = is_onehot;
        decode_d = prio_idx;
`ifdef DECODE_2_4_HOLD_EN
        if (!is_onehot) begin
            decode_d = decode_q;
        end
`else
        // Default build: illegal vectors still take the priority-encoded index.
`endif
    end

    // Output registers with synchronous reset taking priority over inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            decode_q <= IDX_S1;
            legal_q  <= 1'b0;
        end else begin
            decode_q <= decode_d;
            legal_q  <= legal_d;
        end
    end

    assign decode = decode_q;
    assign legal  = legal_q;

endmodule

// File: tb/tb_decode_2_4_enc.sv
// Self-checking bench for decode_2_4_enc: directed steps from the test plan
// followed by counter-driven and random vectors, compared against a
// bit-counting reference model.
module tb_decode_2_4_enc;

    logic       clk = 1'b0;
    logic       reset;
    logic       s1, s2, s3, s4;
    logic [1:0] decode;
    logic       legal;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] exp_dec = 2'b00;
    logic       exp_leg = 1'b0;

    decode_2_4_enc dut (
        .clk    (clk),
        .reset  (reset),
        .s1     (s1),
        .s2     (s2),
        .s3     (s3),
        .s4     (s4),
        .decode (decode),
        .legal  (legal)
    );

    always #5 clk = ~clk;

    // Reference: count active lines, find lowest active line, apply the rules.
    task automatic model(input logic [3:0] v, input logic rst);
        int cnt;
        int first;
        cnt   = 0;
        first = -1;
        for (int b = 0; b < 4; b++) begin
            if (v[b]) begin
                cnt = cnt + 1;
                if (first < 0) first = b;
            end
        end
        if (rst) begin
            exp_dec = 2'b00;
            exp_leg = 1'b0;
        end else if (cnt == 1) begin
            exp_dec = 2'(first);
            exp_leg = 1'b1;
        end else begin
            exp_leg = 1'b0;
`ifdef DECODE_2_4_HOLD_EN
            exp_dec = exp_dec;
`else
            exp_dec = (first < 0) ? 2'b00 : 2'(first);
`endif
        end
    endtask

    // Drive one vector for one cycle, then check the registered result.
    task automatic step(input logic [3:0] v, input logic rst, input string tag);
        @(negedge clk);
        {s4, s3, s2, s1} = v;
        reset = rst;
        model(v, rst);
        @(posedge clk);
        #1;
        n_cmp++;
        assert (decode === exp_dec) else begin
            n_bad++;
            $error("FAIL %s decode v=%b rst=%b got=%b exp=%b", tag, v, rst, decode, exp_dec);
        end
        n_cmp++;
        assert (legal === exp_leg) else begin
            n_bad++;
            $error("FAIL %s legal v=%b rst=%b got=%b exp=%b", tag, v, rst, legal, exp_leg);
        end
    endtask

    initial begin
        logic [7:0] cnt8;
        logic [3:0] rv;
        reset = 1'b1;
        {s4, s3, s2, s1} = 4'b0000;

        // Reset held two cycles with an active input.
        step(4'b0100, 1'b1, "rst0");
        step(4'b0100, 1'b1, "rst1");
        step(4'b0100, 1'b0, "rel");

        // Walk the one-hot vectors.
        step(4'b0001, 1'b0, "walk0");
        step(4'b0010, 1'b0, "walk1");
        step(4'b0100, 1'b0, "walk2");
        step(4'b1000, 1'b0, "walk3");

        // Illegal vectors.
        step(4'b0000, 1'b0, "zero");
        step(4'b1100, 1'b0, "multi");
        step(4'b0110, 1'b0, "ex0110");
        step(4'b1111, 1'b0, "ex1111");

        // Hold-sensitive sequence (checked either way by the model).
        step(4'b1000, 1'b0, "seq_s4");
        step(4'b0011, 1'b0, "seq_0011");
        step(4'b0000, 1'b0, "seq_zero");

        // Reset mid-walk.
        step(4'b0001, 1'b0, "mw0");
        step(4'b0010, 1'b1, "mw_rst");
        step(4'b0100, 1'b0, "mw2");
        step(4'b1000, 1'b0, "mw3");

        // Free-running counter low nibble.
        cnt8 = 8'd0;
        for (int i = 0; i < 40; i++) begin
            step(cnt8[3:0], 1'b0, "cnt");
            cnt8 = cnt8 + 8'd1;
        end

        // Random vectors with occasional reset.
        for (int i = 0; i < 100; i++) begin
            rv = 4'($urandom_range(0, 15));
            step(rv, ($urandom_range(0, 15) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
